vga_frame_out: RTL and testbench

- Display-side endpoint of the pixel pipeline.
- Generates 640x480@60 raster timing and publishes pixelX/pixelY to the object drawing blocks.
- Receives the final 8-bit RRRGGGBB colour back from the object priority mux and expands it to 8:8:8 for the VGA DAC.
- Drives the sync and blank pins, delay-matched to the pixel pipeline latency.

---
 rtl/vga_frame_out.sv | 188 ++++++++++++++++++
 tb/tb_vga_frame_out.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/vga_frame_out.sv
// vga_frame_out: raster timing generator and VGA pin driver for the pixel pipeline.
// Publishes pixelX/pixelY, takes back the composed RRRGGGBB colour PIPE_DELAY clocks
// later, and drives DAC colour, sync and blank with the decodes delay-matched to it.
// Optional colour-bar source: define VGA_TEST_PATTERN_EN to add testPatternSel.
module vga_frame_out #(
  parameter int unsigned H_ACTIVE   = 640,
  parameter int unsigned H_FP       = 16,
  parameter int unsigned H_SYNC     = 96,
  parameter int unsigned H_BP       = 48,
  parameter int unsigned V_ACTIVE   = 480,
  parameter int unsigned V_FP       = 10,
  parameter int unsigned V_SYNC     = 2,
  parameter int unsigned V_BP       = 33,
  parameter int unsigned PIPE_DELAY = 1
) (
  input  logic        clk,
  input  logic        resetN,
`ifdef VGA_TEST_PATTERN_EN
  input  logic        testPatternSel,
`endif
  input  logic [7:0]  RGBIn,
  output logic [10:0] pixelX,
  output logic [10:0] pixelY,
  output logic        startOfFrame,
  output logic [7:0]  oVGA_R,
  output logic [7:0]  oVGA_G,
  output logic [7:0]  oVGA_B,
  output logic        oVGA_HS,
  output logic        oVGA_VS,
  output logic        oVGA_BLANK_N
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_LAST   = 11'(V_TOTAL - 1);
  localparam logic [10:0] H_VIS    = 11'(H_ACTIVE);
  localparam logic [10:0] V_VIS    = 11'(V_ACTIVE);
  localparam logic [10:0] HS_START = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] VS_START = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS_END   = 11'(V_ACTIVE + V_FP + V_SYNC);

  logic                  run;
  logic                  act_now;
  logic                  hs_now;
  logic                  vs_now;
  logic [PIPE_DELAY-1:0] act_sr;
  logic [PIPE_DELAY-1:0] hs_sr;
  logic [PIPE_DELAY-1:0] vs_sr;
  logic [7:0]            colour;

  // The first clock after release holds (0,0) so startOfFrame is seen there.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) run <= 1'b0;
    else         run <= 1'b1;
  end

  // Raster counters: X every clock, Y on X wrap, both wrap together at frame end.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      pixelX <= '0;
      pixelY <= '0;
    end else if (run) begin
      if (pixelX == H_LAST) begin
        pixelX <= '0;
        pixelY <= (pixelY == V_LAST) ? '0 : pixelY + 11'd1;
      end else begin
        pixelX <= pixelX + 11'd1;
      end
    end
  end

  // Frame marker and timing decodes of the current coordinate.
  always_comb begin
    startOfFrame = run && (pixelX == '0) && (pixelY == '0);
    act_now      = run && (pixelX < H_VIS) && (pixelY < V_VIS);
    hs_now       = !((pixelX >= HS_START) && (pixelX < HS_END));
    vs_now       = !((pixelY >= VS_START) && (pixelY < VS_END));
  end

  // Delay line matching the decodes to the latency of the drawing pipeline.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      act_sr <= '0;
      hs_sr  <= '1;
      vs_sr  <= '1;
    end else begin
      act_sr[0] <= act_now;
      hs_sr[0]  <= hs_now;
      vs_sr[0]  <= vs_now;
      for (int unsigned i = 1; i < PIPE_DELAY; i++) begin
        act_sr[i] <= act_sr[i-1];
        hs_sr[i]  <= hs_sr[i-1];
        vs_sr[i]  <= vs_sr[i-1];
      end
    end
  end

`ifdef VGA_TEST_PATTERN_EN
  logic [6:0] bar_px;
  logic [2:0] bar_idx;
  logic [7:0] pat_now;
  logic [7:0] pat_sr [PIPE_DELAY];

  // Bar counter tracks pixelX: bar_idx = pixelX/80 across the visible span.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      bar_px  <= '0;
      bar_idx <= '0;
    end else if (run) begin
      if (pixelX == H_LAST) begin
        bar_px  <= '0;
        bar_idx <= '0;
      end else if (pixelX < H_VIS) begin
        if (bar_px == 7'd79) begin
          bar_px <= '0;
          if (bar_idx != 3'd7) bar_idx <= bar_idx + 3'd1;
        end else begin
          bar_px <= bar_px + 7'd1;
        end
      end
    end
  end

  // Bar colour lookup, left to right.
  always_comb begin
    pat_now = 8'h00;
    case (bar_idx)
      3'd0:    pat_now = 8'hFF;
      3'd1:    pat_now = 8'hFC;
      3'd2:    pat_now = 8'h1F;
      3'd3:    pat_now = 8'h1C;
      3'd4:    pat_now = 8'hE3;
      3'd5:    pat_now = 8'hE0;
      3'd6:    pat_now = 8'h03;
      default: pat_now = 8'h00;
    endcase
  end

  // Pattern colour is delayed like RGBIn so it lands with the same coordinate.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      for (int unsigned i = 0; i < PIPE_DELAY; i++) pat_sr[i] <= '0;
    end else begin
      pat_sr[0] <= pat_now;
      for (int unsigned i = 1; i < PIPE_DELAY; i++) pat_sr[i] <= pat_sr[i-1];
    end
  end

  // Colour source select.
  always_comb begin
    colour = testPatternSel ? pat_sr[PIPE_DELAY-1] : RGBIn;
  end
`else
  // Colour source is always the pipeline.
  always_comb begin
    colour = RGBIn;
  end
`endif

  // Output register: expand RRRGGGBB to 8:8:8, blank outside the visible area.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      oVGA_R       <= '0;
      oVGA_G       <= '0;
      oVGA_B       <= '0;
      oVGA_HS      <= 1'b1;
      oVGA_VS      <= 1'b1;
      oVGA_BLANK_N <= 1'b0;
    end else begin
      oVGA_HS      <= hs_sr[PIPE_DELAY-1];
      oVGA_VS      <= vs_sr[PIPE_DELAY-1];
      oVGA_BLANK_N <= act_sr[PIPE_DELAY-1];
      if (act_sr[PIPE_DELAY-1]) begin
        oVGA_R <= {colour[7:5], colour[7:5], colour[7:6]};
        oVGA_G <= {colour[4:2], colour[4:2], colour[4:3]};
        oVGA_B <= {4{colour[1:0]}};
      end else begin
        oVGA_R <= '0;
        oVGA_G <= '0;
        oVGA_B <= '0;
      end
    end
  end

endmodule

// File: tb/tb_vga_frame_out.sv
// Scoreboard bench for vga_frame_out using a reduced raster so whole frames fit.
module tb_vga_frame_out;

  localparam int HA = 200, HFP = 8, HSW = 16, HBP = 8;
  localparam int VA = 4,   VFP = 2, VSW = 2,  VBP = 2;
  localparam int PD = 2;
  localparam int HT = HA + HFP + HSW + HBP;
  localparam int VT = VA + VFP + VSW + VBP;
  localparam int FRAME = HT * VT;

  logic        clk = 1'b0;
  logic        resetN = 1'b0;
  logic [7:0]  RGBIn = 8'h00;
  logic [10:0] pixelX, pixelY;
  logic        startOfFrame;
  logic [7:0]  oVGA_R, oVGA_G, oVGA_B;
  logic        oVGA_HS, oVGA_VS, oVGA_BLANK_N;
`ifdef VGA_TEST_PATTERN_EN
  logic        testPatternSel = 1'b0;
`endif

  always #5 clk = ~clk;

  vga_frame_out #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
    .PIPE_DELAY(PD)
  ) dut (
    .clk(clk),
    .resetN(resetN),
`ifdef VGA_TEST_PATTERN_EN
    .testPatternSel(testPatternSel),
`endif
    .RGBIn(RGBIn),
    .pixelX(pixelX),
    .pixelY(pixelY),
    .startOfFrame(startOfFrame),
    .oVGA_R(oVGA_R),
    .oVGA_G(oVGA_G),
    .oVGA_B(oVGA_B),
    .oVGA_HS(oVGA_HS),
    .oVGA_VS(oVGA_VS),
    .oVGA_BLANK_N(oVGA_BLANK_N)
  );

  typedef struct {
    int x; int y; int sof;
    int r; int g; int b;
    int hs; int vs; int bl;
  } exp_t;

  exp_t sbq[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   mon_on = 1'b0;
  int   n = -2;            // -2: in reset, -1: first clock after release, 0: first (0,0)
  logic [7:0] prev_rgb = 8'h00;
  bit   prev_sel = 1'b0;

  // 3-bit channel scaled to 8 bits by bit replication; 2-bit channel times 85.
  function automatic int scale3(input int v);
    return (v << 5) | (v << 2) | (v >> 1);
  endfunction

  function automatic logic [7:0] bar_colour(input int x);
    logic [7:0] tbl [8];
    int bar;
    tbl = '{8'hFF, 8'hFC, 8'h1F, 8'h1C, 8'hE3, 8'hE0, 8'h03, 8'h00};
    bar = x / 80;
    if (bar > 7) bar = 7;
    return tbl[bar];
  endfunction

  task automatic chk(input string name, input int act, input int exp_v);
    n_cmp++;
    if (act != exp_v) begin
      n_bad++;
      $display("FAIL %s at t=%0t: got %0h expected %0h", name, $time, act, exp_v);
    end
  endtask

  // One clock of stimulus plus the expected pin state for this same clock.
  task automatic step(input bit rst_low);
    exp_t e;
    int m, k, x, y;
    logic [7:0] rgb_now, c;
    bit sel_now;
    @(posedge clk);
    #2;
    if (rst_low)       begin resetN = 1'b0; n = -2; end
    else if (n == -2)  begin resetN = 1'b1; n = -1; end
    else               n++;

    rgb_now = 8'($urandom);
    sel_now = 1'b0;
`ifdef VGA_TEST_PATTERN_EN
    sel_now = ($urandom_range(0, 2) == 0);
`endif
    m = n - PD;            // coordinate whose colour is due on RGBIn now
    if (m >= 0) begin
      x = m % HT;
      y = (m / HT) % VT;
      if ((m / FRAME) == 1) rgb_now = 8'hFF;
      if (y == 1 && x == 10) rgb_now = 8'hE0;
      if (y == 1 && x == 11) rgb_now = 8'h49;
    end
    RGBIn = rgb_now;
`ifdef VGA_TEST_PATTERN_EN
    testPatternSel = sel_now;
`endif

    e.x   = (n < 0) ? 0 : n % HT;
    e.y   = (n < 0) ? 0 : (n / HT) % VT;
    e.sof = (n >= 0 && n % FRAME == 0) ? 1 : 0;
    k = n - PD - 1;        // coordinate the pins show now
    if (k < 0) begin
      e.r = 0; e.g = 0; e.b = 0; e.hs = 1; e.vs = 1; e.bl = 0;
    end else begin
      x = k % HT;
      y = (k / HT) % VT;
      e.bl = (x < HA && y < VA) ? 1 : 0;
      e.hs = (x >= HA + HFP && x < HA + HFP + HSW) ? 0 : 1;
      e.vs = (y >= VA + VFP && y < VA + VFP + VSW) ? 0 : 1;
      c = prev_sel ? bar_colour(x) : prev_rgb;
      if (e.bl == 1) begin
        e.r = scale3(int'(c[7:5]));
        e.g = scale3(int'(c[4:2]));
        e.b = int'(c[1:0]) * 85;
      end else begin
        e.r = 0; e.g = 0; e.b = 0;
      end
    end
    sbq.push_back(e);
    prev_rgb = rgb_now;
    prev_sel = sel_now;
    mon_on = 1'b1;
  endtask

  // Monitor: every clock the DUT presents a pixel; compare it to the queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (mon_on) begin
        if (sbq.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL scoreboard_empty at t=%0t: got 0 entries expected 1", $time);
        end else begin
          e = sbq.pop_front();
          chk("pixelX",       int'(pixelX),       e.x);
          chk("pixelY",       int'(pixelY),       e.y);
          chk("startOfFrame", int'(startOfFrame), e.sof);
          chk("oVGA_R",       int'(oVGA_R),       e.r);
          chk("oVGA_G",       int'(oVGA_G),       e.g);
          chk("oVGA_B",       int'(oVGA_B),       e.b);
          chk("oVGA_HS",      int'(oVGA_HS),      e.hs);
          chk("oVGA_VS",      int'(oVGA_VS),      e.vs);
          chk("oVGA_BLANK_N", int'(oVGA_BLANK_N), e.bl);
        end
      end
    end
  end

  initial begin
    repeat (3) step(1'b1);
    for (int i = 0; i < 2 * FRAME + 2 * HT; i++) step(1'b0);
    // advance to mid-frame, mid-line, then reset for 3 clocks
    for (int i = 0; i < FRAME; i++) begin
      if (n >= 0 && n % HT == 150 && (n / HT) % VT == 2) break;
      step(1'b0);
    end
    repeat (3) step(1'b1);
    for (int i = 0; i < FRAME + 50; i++) step(1'b0);
    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
